uart_echo_responder: RTL and testbench

- Responder end of the UART link: consumes bytes delivered by the UART receiver and sends each one back through the UART transmitter's start/done handshake.
- Sits between the receiver (rx_data/rx_done) and the transmitter (tx_start/tx_data/tx_done).
- An internal FIFO decouples bursty reception from the slower transmit. An optional XOR mask is applied to each echoed byte.

---
 rtl/uart_echo_responder.sv | 172 +++++++++++++++++
 tb/tb_uart_echo_responder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
// -----------------------------------------------------------------------------
// uart_echo_responder
//
// Purpose:
//   Responder end of a UART link. Bytes handed over by the UART receiver are
//   buffered in a small FIFO and sent back, one frame at a time, through the
//   UART transmitter's start/done handshake. Each echoed byte is XORed with a
//   constant mask (8'h00 gives a pure echo).
//
// Parameters:
//   FIFO_DEPTH : byte capacity of the echo FIFO (power of two, 2..256)
//   XOR_MASK   : constant XORed onto every byte at transmit time
//
// Ports:
//   i_clk        : system clock
//   i_aresetn    : synchronous, active-low reset
//   i_rx_data    : received byte, valid only while i_rx_done is high
//   i_rx_done    : one-cycle pulse, i_rx_data holds a new byte
//   i_tx_done    : one-cycle pulse from the transmitter, frame complete
//   o_tx_start   : one-cycle pulse requesting transmission of o_tx_data
//   o_tx_data    : byte to transmit, held from o_tx_start until i_tx_done
//   o_fifo_count : current FIFO occupancy
//   o_overflow   : sticky, a received byte was dropped on a full FIFO
//   o_busy       : FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
module uart_echo_responder #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  XOR_MASK   = 8'h00
) (
    input  logic                            i_clk,
    input  logic                            i_aresetn,
    input  logic [7:0]                      i_rx_data,
    input  logic                            i_rx_done,
    input  logic                            i_tx_done,
    output logic                            o_tx_start,
    output logic [7:0]                      o_tx_data,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
    output logic                            o_overflow,
    output logic                            o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_tx_data;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_tx_start;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // The pop decision uses the registered count, so a byte arriving into an
    // empty FIFO cannot be popped in the same cycle it is written.
    assign w_pop  = (r_state == S_IDLE) && !w_empty;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push = i_rx_done && (!w_full || w_pop);
    assign w_drop = i_rx_done && w_full && !w_pop;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_tx_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_tx_start = 1'b0;
        if (r_state == S_START) begin
            w_tx_start = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage: plain array, written on push, no reset so it maps to RAM
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO pointers, occupancy, overflow flag and transmit data register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                // Registered read; on a full FIFO with simultaneous push the
                // write targets this same slot, and the old head is read.
                r_tx_data <= r_mem[r_rd_ptr] ^ XOR_MASK;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_tx_start   = w_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_responder
//
// Self-checking bench for uart_echo_responder. One instance uses the default
// pure-echo mask, a second uses XOR_MASK=8'hFF. Expected bytes are queued when
// stimulus is driven and popped when the DUT raises o_tx_start. Outputs are
// sampled on the falling clock edge, inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_echo_responder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;

    // Pure-echo instance
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       busy;

    // Masked instance
    logic [7:0] x_rx_data;
    logic       x_rx_done;
    logic       x_tx_done;
    logic       x_tx_start;
    logic [7:0] x_tx_data;
    logic [4:0] x_fifo_count;
    logic       x_overflow;
    logic       x_busy;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];

    uart_echo_responder #(
        .FIFO_DEPTH (16),
        .XOR_MASK   (8'h00)
    ) dut (
        .i_clk        (clk),
        .i_aresetn    (rstn),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    uart_echo_responder #(
        .FIFO_DEPTH (16),
        .XOR_MASK   (8'hFF)
    ) dut_x (
        .i_clk        (clk),
        .i_aresetn    (rstn),
        .i_rx_data    (x_rx_data),
        .i_rx_done    (x_rx_done),
        .i_tx_done    (x_tx_done),
        .o_tx_start   (x_tx_start),
        .o_tx_data    (x_tx_data),
        .o_fifo_count (x_fifo_count),
        .o_overflow   (x_overflow),
        .o_busy       (x_busy)
    );

    // Waits (bounded) for a start pulse on the pure-echo instance, returns the
    // byte, then answers with i_tx_done dly cycles later. Does no checking.
    task automatic serve_one(input int dly, output bit ok, output logic [7:0] d);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                d  = tx_data;
            end
        end
        if (ok) begin
            repeat (dly) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        x_rx_done = 1'b0;
        x_tx_done = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (x_busy !== 1'b0 || x_tx_data !== 8'h00) begin bad++; $display("FAIL reset_x got busy=%b data=%h want busy=0 data=00", x_busy, x_tx_data); end
        rstn = 1'b1;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_single_echo();
        logic [7:0] e;
        int         stuck;
        @(negedge clk);
        rx_data = 8'hA5; rx_done = 1'b1; exp_q.push_back(8'hA5);
        @(negedge clk);
        rx_done = 1'b0;
        total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL single_count_n1 got=%0d want=1", fifo_count); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_n1 got=%b want=0", tx_start); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_n1 got=%b want=1", busy); end
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_n2 got=%b want=1", tx_start); end
        total++; if (tx_data !== e) begin bad++; $display("FAIL single_data got=%h want=%h", tx_data, e); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL single_count_n2 got=%0d want=0", fifo_count); end
        $display("single: echo byte %h", tx_data);
        stuck = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || busy !== 1'b1) stuck++;
        end
        total++; if (stuck !== 0) begin bad++; $display("FAIL single_wait got=%0d bad cycles want=0", stuck); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_after got=%b want=0", tx_start); end
    endtask

    task automatic test_burst();
        int         peak;
        int         extra;
        bit         ok;
        logic [7:0] d;
        logic [7:0] e;
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    @(negedge clk);
                    rx_data = 8'(i); rx_done = 1'b1; exp_q.push_back(8'(i));
                end
                @(negedge clk);
                rx_done = 1'b0;
            end
            begin
                for (int c = 0; c < 90; c++) begin
                    @(negedge clk);
                    if (int'(fifo_count) > peak) peak = int'(fifo_count);
                end
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    serve_one(10, ok, d);
                    total++;
                    if (!ok) begin
                        bad++; $display("FAIL burst_timeout frame=%0d got=no start want=start", k);
                    end else if (exp_q.size() == 0) begin
                        bad++; $display("FAIL burst_extra frame=%0d got=%h want=none", k, d);
                    end else begin
                        e = exp_q.pop_front();
                        if (d !== e) begin bad++; $display("FAIL burst_data frame=%0d got=%h want=%h", k, d, e); end
                        else $display("burst: echo byte %h", d);
                    end
                end
            end
        join
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL burst_extra_starts got=%0d want=0", extra); end
        total++; if (peak !== 4) begin bad++; $display("FAIL burst_peak got=%0d want=4", peak); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL burst_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit         seen;
        bit         ok;
        logic [7:0] first;
        logic [7:0] d;
        logic [7:0] e;
        apply_reset();
        seen  = 1'b0;
        first = 8'h00;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1 && !seen) begin seen = 1'b1; first = tx_data; end
            rx_data = 8'(i); rx_done = 1'b1;
            if (i < 17) exp_q.push_back(8'(i));
        end
        @(negedge clk);
        rx_done = 1'b0;
        e = exp_q.pop_front();
        total++; if (!seen) begin bad++; $display("FAIL ovf_first_start got=none want=start"); end
        total++; if (first !== e) begin bad++; $display("FAIL ovf_first_data got=%h want=%h", first, e); end
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        $display("overflow: in flight %h, count %0d, flag %b", first, fifo_count, overflow);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            serve_one(2, ok, d);
            total++;
            if (!ok) begin
                bad++; $display("FAIL ovf_timeout frame=%0d got=no start want=start", k);
            end else begin
                e = exp_q.pop_front();
                if (d !== e) begin bad++; $display("FAIL ovf_data frame=%0d got=%h want=%h", k, d, e); end
                else $display("overflow: echo byte %h", d);
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_drained got=%0d want=0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        bit         seen;
        bit         ok;
        int         extra;
        logic [7:0] d;
        logic [7:0] e;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) seen = 1'b1;
            rx_data = 8'h10 + 8'(i); rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        total++; if (!seen || fifo_count !== 5'd3) begin bad++; $display("FAIL rmid_pre got start=%b count=%0d want start=1 count=3", seen, fifo_count); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b want=0", tx_start); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow got=%b want=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rmid_spurious got=%0d starts want=0", extra); end
        @(negedge clk);
        rx_data = 8'h55; rx_done = 1'b1; exp_q.push_back(8'h55);
        @(negedge clk);
        rx_done = 1'b0;
        serve_one(3, ok, d);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rmid_timeout got=no start want=start");
        end else begin
            e = exp_q.pop_front();
            if (d !== e) begin bad++; $display("FAIL rmid_data got=%h want=%h", d, e); end
            else $display("reset_mid: echo byte %h", d);
        end
    endtask

    task automatic test_full_simul_pop();
        bit         ok;
        logic [7:0] d;
        logic [7:0] e;
        apply_reset();
        @(negedge clk);
        rx_data = 8'hAA; rx_done = 1'b1; exp_q.push_back(8'hAA);
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if (tx_start !== 1'b1 || tx_data !== e) begin bad++; $display("FAIL full_first got start=%b data=%h want start=1 data=%h", tx_start, tx_data, e); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rx_data = 8'hB0 + 8'(i); rx_done = 1'b1; exp_q.push_back(8'hB0 + 8'(i));
        end
        @(negedge clk);
        rx_done = 1'b0;
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL full_filled got=%0d want=16", fifo_count); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        rx_data = 8'h77; rx_done = 1'b1; exp_q.push_back(8'h77);
        @(negedge clk);
        rx_done = 1'b0;
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL full_simul_count got=%0d want=16", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_simul_overflow got=%b want=0", overflow); end
        e = exp_q.pop_front();
        total++; if (tx_start !== 1'b1 || tx_data !== e) begin bad++; $display("FAIL full_simul_head got start=%b data=%h want start=1 data=%h", tx_start, tx_data, e); end
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            serve_one(2, ok, d);
            total++;
            if (!ok) begin
                bad++; $display("FAIL full_timeout frame=%0d got=no start want=start", k);
            end else begin
                e = exp_q.pop_front();
                if (d !== e) begin bad++; $display("FAIL full_data frame=%0d got=%h want=%h", k, d, e); end
                else $display("full: echo byte %h", d);
            end
        end
        total++; if (overflow !== 1'b0 || exp_q.size() !== 0) begin bad++; $display("FAIL full_end got ovf=%b left=%0d want ovf=0 left=0", overflow, exp_q.size()); end
    endtask

    task automatic test_xor_mask();
        int extra;
        // Spurious done while idle
        @(negedge clk);
        x_tx_done = 1'b1;
        @(negedge clk);
        x_tx_done = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (x_tx_start === 1'b1 || x_busy !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL xor_spurious_idle got=%0d bad cycles want=0", extra); end
        x_rx_data = 8'h3C; x_rx_done = 1'b1;
        @(negedge clk);
        x_rx_done = 1'b0;
        @(negedge clk);
        total++; if (x_tx_start !== 1'b1) begin bad++; $display("FAIL xor_start got=%b want=1", x_tx_start); end
        total++; if (x_tx_data !== 8'hC3) begin bad++; $display("FAIL xor_data got=%h want=c3", x_tx_data); end
        $display("xor: echo byte %h", x_tx_data);
        repeat (2) @(negedge clk);
        x_tx_done = 1'b1;
        @(negedge clk);
        x_tx_done = 1'b0;
        total++; if (x_busy !== 1'b0) begin bad++; $display("FAIL xor_busy_after got=%b want=0", x_busy); end
        @(negedge clk);
        x_tx_done = 1'b1;
        @(negedge clk);
        x_tx_done = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (x_tx_start === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL xor_spurious_after got=%0d starts want=0", extra); end
        total++; if (x_tx_data !== 8'hC3) begin bad++; $display("FAIL xor_hold got=%h want=c3", x_tx_data); end
    endtask

    initial begin
        rstn      = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        tx_done   = 1'b0;
        x_rx_data = 8'h00;
        x_rx_done = 1'b0;
        x_tx_done = 1'b0;
        test_reset();
        test_single_echo();
        test_burst();
        test_overflow();
        test_reset_mid();
        test_full_simul_pop();
        test_xor_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
